// File: rtl/mux_console_if.sv
`default_nettype none
// ============================================================================
//  Module   : mux_console_if
//  Purpose  : CPU-side register bus of the serial console port. The CPU (or
//             the bus fabric) uses the master modport and the console uses
//             the slave modport.
//  Revision : 1.0 - initial release
// ============================================================================
interface mux_console_if;
    logic [15:0] address;
    logic [7:0]  dataIn;
    logic        writeEn;
    logic        readEn;
    logic [7:0]  dataOut;
    logic        sel;

    modport master (
        output address,
        output dataIn,
        output writeEn,
        output readEn,
        input  dataOut,
        input  sel
    );

    modport slave (
        input  address,
        input  dataIn,
        input  writeEn,
        input  readEn,
        output dataOut,
        output sel
    );
endinterface
`default_nettype wire

// File: rtl/mux_console.sv
`default_nettype none
// ============================================================================
//  Module   : mux_console
//  Purpose  : Memory-mapped 8N1 serial console. A two-byte window (status at
//             BASE, data at BASE+1) feeds a small transmit FIFO and a TX
//             serialiser. Defining MUX_CONSOLE_RX_EN compiles in a receiver
//             with a single holding register and its status flags.
//  Revision : 1.0 - initial release
// ============================================================================
module mux_console #(
    parameter logic [15:0] BASE         = 16'hF200,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          TX_DEPTH     = 4
) (
    input  wire logic   clock,
    input  wire logic   reset,
    mux_console_if.slave bus,
    input  wire logic   rx,
    output logic        tx
);

    localparam int c_PW = $clog2(TX_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_BW = $clog2(CLKS_PER_BIT);

    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_FULL      = c_CW'(TX_DEPTH);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic w_sel_stat;
    logic w_sel_data;
    logic w_push;
    logic w_stat_wr;

    assign w_sel_stat = (bus.address == BASE);
    assign w_sel_data = (bus.address == BASE + 16'd1);
    assign w_push     = bus.writeEn && w_sel_data;
    assign w_stat_wr  = bus.writeEn && w_sel_stat;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]      r_fifo [TX_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_full;
    logic            w_fifo_ne;
    logic            w_push_ok;
    logic            w_tx_pop;

    // The full test uses the pre-edge count, so a same-edge pop cannot rescue
    // a write into a full FIFO.
    assign w_full    = (r_count == c_FULL);
    assign w_fifo_ne = (r_count != '0);
    assign w_push_ok = w_push && !w_full;

    // FIFO storage: no reset needed, the count qualifies every entry.
    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= bus.dataIn;
        end
    end

    // FIFO pointers and occupancy count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_tx_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            case ({w_push_ok, w_tx_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    logic [1:0]      r_tx_state;
    logic [1:0]      w_tx_state_nxt;
    logic [c_BW-1:0] r_tx_baud;
    logic [2:0]      r_tx_idx;
    logic [7:0]      r_tx_shift;
    logic            w_tx_baud_done;

    assign w_tx_baud_done = (r_tx_baud == c_BAUD_LAST);

    // TX state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_state <= c_ST_IDLE;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    // TX next-state: STOP chains straight into START when more data waits.
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            c_ST_IDLE:  if (w_fifo_ne) w_tx_state_nxt = c_ST_START;
            c_ST_START: if (w_tx_baud_done) w_tx_state_nxt = c_ST_DATA;
            c_ST_DATA:  if (w_tx_baud_done && (r_tx_idx == 3'd7)) w_tx_state_nxt = c_ST_STOP;
            c_ST_STOP: begin
                if (w_tx_baud_done) begin
                    w_tx_state_nxt = w_fifo_ne ? c_ST_START : c_ST_IDLE;
                end
            end
            default:    w_tx_state_nxt = c_ST_IDLE;
        endcase
    end

    // TX outputs: FIFO pop strobe.
    always_comb begin
        w_tx_pop = 1'b0;
        case (r_tx_state)
            c_ST_IDLE: w_tx_pop = w_fifo_ne;
            c_ST_STOP: w_tx_pop = w_tx_baud_done && w_fifo_ne;
            default:   w_tx_pop = 1'b0;
        endcase
    end

    // TX datapath: baud counter, bit index, shifter and registered line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_baud  <= '0;
            r_tx_idx   <= 3'd0;
            r_tx_shift <= 8'h00;
            tx         <= 1'b1;
        end else if (w_tx_pop) begin
            r_tx_shift <= r_fifo[r_rd_ptr];
            r_tx_baud  <= '0;
            tx         <= 1'b0;
        end else begin
            case (r_tx_state)
                c_ST_START: begin
                    if (w_tx_baud_done) begin
                        r_tx_baud  <= '0;
                        r_tx_idx   <= 3'd0;
                        tx         <= r_tx_shift[0];
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                    end else begin
                        r_tx_baud <= r_tx_baud + c_BW'(1);
                    end
                end
                c_ST_DATA: begin
                    if (w_tx_baud_done) begin
                        r_tx_baud <= '0;
                        r_tx_idx  <= r_tx_idx + 3'd1;
                        if (r_tx_idx == 3'd7) begin
                            tx <= 1'b1;
                        end else begin
                            tx         <= r_tx_shift[0];
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        end
                    end else begin
                        r_tx_baud <= r_tx_baud + c_BW'(1);
                    end
                end
                c_ST_STOP: begin
                    tx <= 1'b1;
                    if (w_tx_baud_done) begin
                        r_tx_baud <= '0;
                    end else begin
                        r_tx_baud <= r_tx_baud + c_BW'(1);
                    end
                end
                default: begin
                    r_tx_baud <= '0;
                    tx        <= 1'b1;
                end
            endcase
        end
    end

    // TX_OVERRUN: sticky; a same-edge status write loses to a new drop.
    logic r_tx_overrun;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tx_overrun <= 1'b0;
        end else if (w_push && w_full) begin
            r_tx_overrun <= 1'b1;
        end else if (w_stat_wr) begin
            r_tx_overrun <= 1'b0;
        end
    end

    logic w_tx_ready;
    logic w_tx_busy;
    assign w_tx_ready = (r_count < c_FULL);
    assign w_tx_busy  = (r_tx_state != c_ST_IDLE) || w_fifo_ne;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic       w_rx_ready;
    logic       w_rx_framing;
    logic       w_rx_overrun;
    logic [7:0] w_rx_data;

`ifdef MUX_CONSOLE_RX_EN
    localparam logic [c_BW-1:0] c_HALF_LAST = c_BW'(CLKS_PER_BIT / 2 - 1);

    logic            r_rx_s1;
    logic            r_rx_s2;
    logic            r_rx_prev;
    logic [1:0]      r_rx_state;
    logic [1:0]      w_rx_state_nxt;
    logic [c_BW-1:0] r_rx_baud;
    logic [2:0]      r_rx_idx;
    logic [7:0]      r_rx_shift;
    logic [7:0]      r_rx_hold;
    logic            r_rx_ready;
    logic            r_rx_framing;
    logic            r_rx_overrun;
    logic            w_rx_bit_smp;
    logic            w_rx_stop_smp;
    logic            w_rx_done_ok;
    logic            w_rd_clear;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
        end
    end

    // RX state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_state <= c_ST_IDLE;
        end else begin
            r_rx_state <= w_rx_state_nxt;
        end
    end

    // RX next-state: a high mid-start sample is treated as a glitch.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        case (r_rx_state)
            c_ST_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_state_nxt = c_ST_START;
            c_ST_START: begin
                if (r_rx_baud == c_HALF_LAST) begin
                    w_rx_state_nxt = r_rx_s2 ? c_ST_IDLE : c_ST_DATA;
                end
            end
            c_ST_DATA:  if ((r_rx_baud == c_BAUD_LAST) && (r_rx_idx == 3'd7)) w_rx_state_nxt = c_ST_STOP;
            c_ST_STOP:  if (r_rx_baud == c_BAUD_LAST) w_rx_state_nxt = c_ST_IDLE;
            default:    w_rx_state_nxt = c_ST_IDLE;
        endcase
    end

    // RX outputs: data-bit and stop-bit sample strobes.
    always_comb begin
        w_rx_bit_smp  = 1'b0;
        w_rx_stop_smp = 1'b0;
        case (r_rx_state)
            c_ST_DATA: w_rx_bit_smp  = (r_rx_baud == c_BAUD_LAST);
            c_ST_STOP: w_rx_stop_smp = (r_rx_baud == c_BAUD_LAST);
            default: begin
                w_rx_bit_smp  = 1'b0;
                w_rx_stop_smp = 1'b0;
            end
        endcase
    end

    // RX datapath: baud counter restarts at each phase boundary, LSB-first shift.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_baud  <= '0;
            r_rx_idx   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            case (r_rx_state)
                c_ST_START: begin
                    r_rx_idx  <= 3'd0;
                    r_rx_baud <= (r_rx_baud == c_HALF_LAST) ? '0 : r_rx_baud + c_BW'(1);
                end
                c_ST_DATA, c_ST_STOP: begin
                    r_rx_baud <= (r_rx_baud == c_BAUD_LAST) ? '0 : r_rx_baud + c_BW'(1);
                end
                default: begin
                    r_rx_baud <= '0;
                    r_rx_idx  <= 3'd0;
                end
            endcase
            if (w_rx_bit_smp) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_idx   <= r_rx_idx + 3'd1;
            end
        end
    end

    assign w_rx_done_ok = w_rx_stop_smp && r_rx_s2;
    assign w_rd_clear   = bus.readEn && w_sel_data;

    // Holding register and RX flags; a same-edge read clear makes room for the new byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_hold    <= 8'h00;
            r_rx_ready   <= 1'b0;
            r_rx_framing <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            if (w_rx_done_ok && (!r_rx_ready || w_rd_clear)) begin
                r_rx_hold  <= r_rx_shift;
                r_rx_ready <= 1'b1;
            end else if (w_rd_clear) begin
                r_rx_ready <= 1'b0;
            end

            if (w_rx_done_ok && r_rx_ready && !w_rd_clear) begin
                r_rx_overrun <= 1'b1;
            end else if (w_stat_wr) begin
                r_rx_overrun <= 1'b0;
            end

            if (w_rx_stop_smp && !r_rx_s2) begin
                r_rx_framing <= 1'b1;
            end else if (w_stat_wr) begin
                r_rx_framing <= 1'b0;
            end
        end
    end

    assign w_rx_ready   = r_rx_ready;
    assign w_rx_framing = r_rx_framing;
    assign w_rx_overrun = r_rx_overrun;
    assign w_rx_data    = r_rx_hold;
`else
    logic w_unused_rx_inputs;
    assign w_unused_rx_inputs = rx ^ bus.readEn;

    assign w_rx_ready   = 1'b0;
    assign w_rx_framing = 1'b0;
    assign w_rx_overrun = 1'b0;
    assign w_rx_data    = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Read mux toward the CPU
    // ------------------------------------------------------------------
    logic [7:0] w_status;
    assign w_status = {2'b00, w_tx_busy, w_rx_overrun, w_rx_framing,
                       r_tx_overrun, w_tx_ready, w_rx_ready};

    // Combinational read data and window select.
    always_comb begin
        bus.sel     = w_sel_stat || w_sel_data;
        bus.dataOut = 8'h00;
        if (w_sel_stat) begin
            bus.dataOut = w_status;
        end else if (w_sel_data) begin
            bus.dataOut = w_rx_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_console.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_console
//  Purpose  : Scoreboard bench for mux_console. Stimulus pushes expected
//             register reads and expected serial frames into queues; two
//             monitors pop and compare as the DUT presents them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_console;

    localparam logic [15:0] c_BASE = 16'hF200;
    localparam int          c_CPB  = 16;
    localparam int          c_DEP  = 4;

    typedef struct {
        logic [7:0] d;
        logic       gap;
    } tx_exp_t;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        s;
        int          id;
    } rd_exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;
    logic tx;

    mux_console_if bus_if ();

    mux_console #(
        .BASE         (c_BASE),
        .CLKS_PER_BIT (c_CPB),
        .TX_DEPTH     (c_DEP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if),
        .rx    (rx),
        .tx    (tx)
    );

    always #5 clock = ~clock;

    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc      = 0;
    int      rd_id    = 0;
    logic    rd_chk   = 1'b0;
    tx_exp_t tx_q [$];
    rd_exp_t rd_q [$];

    always @(posedge clock) cyc <= cyc + 1;

    // Read monitor: compares dataOut/sel whenever the bench presents a read.
    always @(negedge clock) begin
        if (rd_chk) begin
            rd_exp_t x;
            n_checks = n_checks + 1;
            if (rd_q.size() == 0) begin
                n_errors = n_errors + 1;
                $display("FAIL rd_queue: read presented with no expected value");
            end else begin
                x = rd_q.pop_front();
                if (bus_if.dataOut !== x.d || bus_if.sel !== x.s) begin
                    n_errors = n_errors + 1;
                    $display("FAIL rd#%0d addr=%h: got data=%h sel=%b, expected data=%h sel=%b",
                             x.id, x.a, bus_if.dataOut, bus_if.sel, x.d, x.s);
                end
            end
        end
    end

    // Line monitor: checks every cycle of each frame on tx and the inter-frame gap.
    initial begin : line_mon
        int      start_cyc;
        int      last_end;
        logic    have;
        logic    bad;
        logic    aborted;
        logic [9:0] frame;
        logic [7:0] got;
        tx_exp_t e;
        last_end = -1;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                start_cyc = cyc;
                have      = (tx_q.size() != 0);
                e.d       = 8'h00;
                e.gap     = 1'b0;
                if (have) e = tx_q.pop_front();
                frame   = {1'b1, e.d, 1'b0};
                bad     = 1'b0;
                aborted = 1'b0;
                got     = 8'h00;
                for (int i = 0; i < 10 * c_CPB; i++) begin
                    if (i > 0) @(negedge clock);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx !== frame[i / c_CPB]) bad = 1'b1;
                    if ((i % c_CPB) == c_CPB / 2 && i / c_CPB >= 1 && i / c_CPB <= 8)
                        got[i / c_CPB - 1] = tx;
                end
                if (!aborted) begin
                    n_checks = n_checks + 1;
                    if (!have) begin
                        n_errors = n_errors + 1;
                        $display("FAIL tx_frame: unexpected frame got=%h at cycle %0d", got, start_cyc);
                    end else if (bad) begin
                        n_errors = n_errors + 1;
                        $display("FAIL tx_frame: got byte=%h (or bad timing), expected %h", got, e.d);
                    end
                    if (have && e.gap) begin
                        n_checks = n_checks + 1;
                        if (start_cyc != last_end) begin
                            n_errors = n_errors + 1;
                            $display("FAIL tx_gap: frame %h started at cycle %0d, expected %0d",
                                     e.d, start_cyc, last_end);
                        end
                    end
                    last_end = start_cyc + 10 * c_CPB;
                end
            end
        end
    end

    // Stimulus tasks: all are entered one time unit after a rising edge.
    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus_if.address = a;
        bus_if.dataIn  = d;
        bus_if.writeEn = 1'b1;
        @(posedge clock); #1;
        bus_if.writeEn = 1'b0;
        bus_if.address = 16'h0000;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e, input logic es, input logic strobe);
        rd_exp_t x;
        x.a = a; x.d = e; x.s = es; x.id = rd_id;
        rd_id = rd_id + 1;
        rd_q.push_back(x);
        bus_if.address = a;
        bus_if.readEn  = strobe;
        rd_chk         = 1'b1;
        @(posedge clock); #1;
        rd_chk         = 1'b0;
        bus_if.readEn  = 1'b0;
        bus_if.address = 16'h0000;
    endtask

    task automatic exp_tx(input logic [7:0] d, input logic gap);
        tx_exp_t e;
        e.d = d; e.gap = gap;
        tx_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        idle(c_CPB);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            idle(c_CPB);
        end
        rx = stop;
        idle(c_CPB);
        rx = 1'b1;
    endtask

    // Guard against a hung run.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bus_if.address = 16'h0000;
        bus_if.dataIn  = 8'h00;
        bus_if.writeEn = 1'b0;
        bus_if.readEn  = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(1);

        // Reset state.
        n_checks = n_checks + 1;
        if (tx !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL tx_reset: got %b, expected 1", tx);
        end
        rd(c_BASE,          8'h02, 1'b1, 1'b0);
        rd(16'hF1FF,        8'h00, 1'b0, 1'b0);
        rd(c_BASE + 16'd1,  8'h00, 1'b1, 1'b0);
        rd(16'hF202,        8'h00, 1'b0, 1'b0);

        // Single frame 0xA5 and TX_BUSY timing: pop at edge N+1, idle after N+161.
        exp_tx(8'hA5, 1'b0);
        wr(c_BASE + 16'd1, 8'hA5);
        rd(c_BASE, 8'h22, 1'b1, 1'b0);
        idle(159);
        rd(c_BASE, 8'h22, 1'b1, 1'b0);
        rd(c_BASE, 8'h02, 1'b1, 1'b0);

        // Burst of five, then an overrun on the sixth, then clear.
        idle(4);
        exp_tx(8'h01, 1'b0);
        exp_tx(8'h02, 1'b1);
        exp_tx(8'h03, 1'b1);
        exp_tx(8'h04, 1'b1);
        exp_tx(8'h05, 1'b1);
        for (int k = 1; k <= 5; k++) wr(c_BASE + 16'd1, 8'(k));
        rd(c_BASE, 8'h20, 1'b1, 1'b0);
        wr(c_BASE + 16'd1, 8'h06);
        rd(c_BASE, 8'h24, 1'b1, 1'b0);
        wr(c_BASE, 8'h00);
        rd(c_BASE, 8'h20, 1'b1, 1'b0);
        idle(5 * 10 * c_CPB + 20);
        rd(c_BASE, 8'h02, 1'b1, 1'b0);

`ifdef MUX_CONSOLE_RX_EN
        // Single RX byte, peek, then clearing read.
        send_rx(8'h3C, 1'b1);
        idle(4);
        rd(c_BASE,         8'h03, 1'b1, 1'b0);
        rd(c_BASE + 16'd1, 8'h3C, 1'b1, 1'b0);
        rd(c_BASE + 16'd1, 8'h3C, 1'b1, 1'b1);
        rd(c_BASE,         8'h02, 1'b1, 1'b0);

        // Two frames without a read: overrun, first byte kept.
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        idle(4);
        rd(c_BASE,         8'h13, 1'b1, 1'b0);
        rd(c_BASE + 16'd1, 8'h11, 1'b1, 1'b1);
        rd(c_BASE,         8'h12, 1'b1, 1'b0);
        wr(c_BASE, 8'hFF);
        rd(c_BASE,         8'h02, 1'b1, 1'b0);

        // Framing error keeps RX_READY low; a short glitch changes nothing.
        send_rx(8'hA0, 1'b0);
        idle(4);
        rd(c_BASE,         8'h0A, 1'b1, 1'b0);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        rd(c_BASE,         8'h0A, 1'b1, 1'b0);
        rd(c_BASE + 16'd1, 8'h11, 1'b1, 1'b0);
        wr(c_BASE, 8'h00);
        rd(c_BASE,         8'h02, 1'b1, 1'b0);
`endif

        // Reset in the middle of the data bits; no frame expected for 0x77.
        wr(c_BASE + 16'd1, 8'h77);
        wr(c_BASE + 16'd1, 8'h78);
        idle(40);
        reset = 1'b1;
        #1;
        n_checks = n_checks + 1;
        if (tx !== 1'b1) begin
            n_errors = n_errors + 1;
            $display("FAIL tx_midreset: got %b, expected 1", tx);
        end
        idle(2);
        reset = 1'b0;
        idle(1);
        rd(c_BASE, 8'h02, 1'b1, 1'b0);
        exp_tx(8'h5A, 1'b0);
        wr(c_BASE + 16'd1, 8'h5A);
        idle(10 * c_CPB + 10);
        rd(c_BASE, 8'h02, 1'b1, 1'b0);

        // Drain and confirm every expected item was observed.
        for (int k = 0; k < 2000 && tx_q.size() != 0; k++) @(posedge clock);
        idle(2);
        n_checks = n_checks + 1;
        if (tx_q.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL tx_drain: %0d frames outstanding, expected 0", tx_q.size());
        end
        n_checks = n_checks + 1;
        if (rd_q.size() != 0) begin
            n_errors = n_errors + 1;
            $display("FAIL rd_drain: %0d reads outstanding, expected 0", rd_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
